sa_311: RTL and testbench

- Bit-serial N-bit adder: the addition counterpart of the team's combinational full subtractor.
- A single full-adder cell and a carry flip-flop process the operands LSB-first, one bit per clock.
- A start/busy/done handshake brackets each operation.
- Used where area matters more than latency. With b inverted and cin=1 it also yields a-b for cross-checking subtractor results.

---
 rtl/sa_311.sv | 93 +++++++++
 tb/tb_sa_311.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sa_311.sv
// Bit-serial adder: one full-adder cell plus a carry flop, operands consumed LSB-first.
// A start/busy/done handshake brackets each WIDTH-cycle operation.
module sa_311 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic             start_311,
    input  logic [WIDTH-1:0] a_311,
    input  logic [WIDTH-1:0] b_311,
    input  logic             cin_311,
    output logic             busy_311,
    output logic             done_311,
    output logic [WIDTH-1:0] sum_311,
    output logic             cout_311
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_shifted;
    logic [CNT_W-1:0] cnt;
    logic             carry, carry_next, s_bit, last;

    always_ff @(posedge clk_311) begin
        if (rst_311) state <= IDLE;
        else         state <= state_next;
    end

    // Full-adder cell on the current LSBs; the new sum bit enters the MSB of the shifter.
    always_comb begin
        s_bit      = a_reg[0] ^ b_reg[0] ^ carry;
        carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
        s_shifted  = s_reg >> 1;
        s_shifted[WIDTH-1] = s_bit;
        last       = (cnt == LAST);
        state_next = state;
        case (state)
            IDLE:    if (start_311) state_next = SHIFT;
            SHIFT:   if (last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_311 = (state == SHIFT);

    always_ff @(posedge clk_311) begin
        if (rst_311) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_311  <= '0;
            cout_311 <= 1'b0;
            done_311 <= 1'b0;
        end else begin
            done_311 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_311) begin
                        a_reg <= a_311;
                        b_reg <= b_311;
                        carry <= cin_311;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    s_reg <= s_shifted;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    // The result registers see the final bit directly, not the stale shifter.
                    if (last) begin
                        sum_311  <= s_shifted;
                        cout_311 <= carry_next;
                        done_311 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_311.sv
// Directed bench for sa_311 at WIDTH=8 and WIDTH=1, plus a random sweep against a+b+cin.
module tb_sa_311;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_311 #(.WIDTH(8)) u8 (
        .clk_311(clk), .rst_311(rst), .start_311(start8),
        .a_311(a8), .b_311(b8), .cin_311(cin8),
        .busy_311(busy8), .done_311(done8), .sum_311(sum8), .cout_311(cout8)
    );

    sa_311 #(.WIDTH(1)) u1 (
        .clk_311(clk), .rst_311(rst), .start_311(start1),
        .a_311(a1), .b_311(b1), .cin_311(cin1),
        .busy_311(busy1), .done_311(done1), .sum_311(sum1), .cout_311(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with a one-cycle start pulse; returns just after the load edge.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Ticks until done8 is seen (bounded); lat counts edges waited, busy_cnt the busy samples.
    task automatic wait_done8(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic count_done8(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done8 === 1'b1) pulses++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat, bc;
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
        apply_stimulus(a, b, c);
        wait_done8(lat, bc);
        check_output({tag, "_lat"}, lat, 8);
        check_output({tag, "_sum"}, sum8, exp[7:0]);
        check_output({tag, "_cout"}, cout8, exp[8]);
    endtask

    initial begin
        int lat, bc, pulses;
        logic [8:0] exp;
        logic [1:0] exp1;
        logic [7:0] ra, rb;
        logic       rc;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        check_output("rst_busy", busy8, 0);
        check_output("rst_done", done8, 0);
        check_output("rst_sum", sum8, 0);
        check_output("rst_cout", cout8, 0);
        check_output("rst_w1_busy", busy1, 0);
        rst = 1'b0;

        // Basic operation with full latency/busy-length check
        apply_stimulus(8'h3C, 8'h55, 1'b0);
        check_output("e0_busy", busy8, 1);
        wait_done8(lat, bc);
        check_output("basic_lat", lat, 8);
        check_output("basic_busycnt", bc, 8);
        check_output("basic_busy_at_done", busy8, 0);
        check_output("basic_sum", sum8, 8'h91);
        check_output("basic_cout", cout8, 0);
        tick();
        check_output("done_pulse_end", done8, 0);
        check_output("sum_held", sum8, 8'h91);

        run8("ff_01", 8'hFF, 8'h01, 1'b0);
        check_output("ff_01_sum_lit", sum8, 8'h00);
        check_output("ff_01_cout_lit", cout8, 1);
        run8("ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        check_output("ff_ff_sum_lit", sum8, 8'hFF);
        run8("sub", 8'h20, 8'hCA, 1'b1);
        check_output("sub_sum_lit", sum8, 8'hEB);
        check_output("sub_borrow", cout8, 0);

        // Start with new operands during E3 must be ignored
        apply_stimulus(8'h3C, 8'h55, 1'b0);
        tick();
        tick();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(lat, bc);
        check_output("ign_lat", lat, 5);
        check_output("ign_sum", sum8, 8'h91);
        check_output("ign_cout", cout8, 0);
        count_done8(12, pulses);
        check_output("ign_extra_done", pulses, 0);
        check_output("ign_idle", busy8, 0);

        // Reset at E4 aborts the operation
        apply_stimulus(8'hFF, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort_busy", busy8, 0);
        check_output("abort_done", done8, 0);
        check_output("abort_sum", sum8, 0);
        check_output("abort_cout", cout8, 0);
        count_done8(12, pulses);
        check_output("abort_no_done", pulses, 0);
        run8("post_abort", 8'h20, 8'hCA, 1'b1);

        // Back-to-back with start held high: second op accepted in the done cycle
        a8 = 8'h3C; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        wait_done8(lat, bc);
        check_output("b2b1_lat", lat, 8);
        check_output("b2b1_sum", sum8, 8'h91);
        tick();
        start8 = 1'b0;
        check_output("b2b_accept_busy", busy8, 1);
        check_output("b2b_accept_done", done8, 0);
        wait_done8(lat, bc);
        check_output("b2b2_lat", lat, 8);
        check_output("b2b2_sum", sum8, 8'hFF);
        check_output("b2b2_cout", cout8, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run8("rand", ra, rb, rc);
        end

        // WIDTH=1: all eight input combinations
        for (int v = 0; v < 8; v++) begin
            a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
            exp1 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
            tick();
            start1 = 1'b0;
            check_output("w1_busy", busy1, 1);
            lat = 0;
            while (done1 !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            check_output("w1_lat", lat, 1);
            check_output("w1_sum", sum1, exp1[0]);
            check_output("w1_cout", cout1, exp1[1]);
            tick();
            check_output("w1_done_clear", done1, 0);
        end

        exp = '0;
        $display("[TB] directed and random sequences complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
